// File: rtl/exp_add_pipe.sv
// Two-stage exponent adder for FP multiply/divide: S1 forms a+/-b and classifies
// operands, S2 applies the bias, saturates and flags. One global enable stalls both stages.
module exp_add_pipe #(
  parameter int EXP_W = 5,
  parameter int BIAS  = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [EXP_W-1:0] a,
  input  logic [EXP_W-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] c,
  output logic             ovf,
  output logic             unf,
  output logic             zero,
  output logic             special
);
  localparam int SW = EXP_W + 2;
  typedef logic signed [SW-1:0] sum_t;
  localparam sum_t BIAS_S = sum_t'(BIAS);
  localparam sum_t OVF_TH = sum_t'((1 << EXP_W) - 1);
  localparam sum_t ZERO_S = sum_t'(0);

  logic en;
  logic [2:1] vld_pipe_q;

  // S1 state
  sum_t s_q, s_d;
  logic a0_q, b0_q, a1_q, b1_q, mode_q;

  // S2 state
  logic [EXP_W-1:0] c_q, c_d;
  logic ovf_q, ovf_d, unf_q, unf_d, zero_q, zero_d, spec_q, spec_d;
  sum_t r_d;

  assign en        = out_ready | ~vld_pipe_q[2];
  assign in_ready  = en;
  assign out_valid = vld_pipe_q[2];
  assign c         = c_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;
  assign zero      = zero_q;
  assign special   = spec_q;

  // Zero-extended operands keep the sum exact; the extra sign bit covers a-b < 0.
  assign s_d = mode ? ({2'b00, a} - {2'b00, b}) : ({2'b00, a} + {2'b00, b});

  always_comb begin
    r_d    = mode_q ? (s_q + BIAS_S) : (s_q - BIAS_S);
    c_d    = r_d[EXP_W-1:0];
    ovf_d  = 1'b0;
    unf_d  = 1'b0;
    zero_d = 1'b0;
    spec_d = mode_q ? (a1_q | b0_q) : (a1_q | b1_q);
    if (spec_d) begin
      c_d = '1;
    end else if (mode_q ? a0_q : (a0_q | b0_q)) begin
      zero_d = 1'b1;
      c_d    = '0;
    end else if (r_d >= OVF_TH) begin
      ovf_d = 1'b1;
      c_d   = '1;
    end else if (r_d <= ZERO_S) begin
      unf_d = 1'b1;
      c_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      s_q        <= '0;
      a0_q       <= 1'b0;
      b0_q       <= 1'b0;
      a1_q       <= 1'b0;
      b1_q       <= 1'b0;
      mode_q     <= 1'b0;
      c_q        <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      zero_q     <= 1'b0;
      spec_q     <= 1'b0;
    end else if (en) begin
      vld_pipe_q <= {vld_pipe_q[1], in_valid};
      s_q        <= s_d;
      a0_q       <= (a == '0);
      b0_q       <= (b == '0);
      a1_q       <= (a == '1);
      b1_q       <= (b == '1);
      mode_q     <= mode;
      c_q        <= c_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      zero_q     <= zero_d;
      spec_q     <= spec_d;
    end
  end
endmodule

// File: tb/tb_exp_add_pipe.sv
// Directed bench for exp_add_pipe (EXP_W=5, BIAS=15): reset, latency, stalled stream, mid-flight reset.
module tb_exp_add_pipe;
  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, mode, out_valid, out_ready;
  logic [4:0] a, b, c;
  logic       ovf, unf, zero, special;

  int total = 0;
  int bad   = 0;

  localparam int N = 16;
  // flags encoded {ovf,unf,zero,special}
  int vm[N] = '{0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 1};
  int va[N] = '{16, 30, 1, 20, 5, 0, 0, 0, 15, 8, 8, 23, 23, 31, 5, 0};
  int vb[N] = '{17, 30, 1, 10, 0, 31, 10, 10, 16, 8, 7, 23, 22, 5, 31, 0};
  int ec[N] = '{18, 31, 0, 25, 31, 31, 0, 0, 16, 1, 0, 31, 30, 31, 0, 31};
  int ef[N] = '{0, 8, 4, 0, 1, 1, 2, 2, 0, 0, 4, 8, 0, 1, 4, 1};

  exp_add_pipe #(.EXP_W(5), .BIAS(15)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .ovf(ovf), .unf(unf), .zero(zero), .special(special)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] flags();
    return {28'd0, ovf, unf, zero, special};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i);
    in_valid = 1'b1;
    mode     = vm[i][0];
    a        = va[i][4:0];
    b        = vb[i][4:0];
  endtask

  initial begin
    int  wr, rd;
    bit  acc, prev_stall;
    logic [4:0] held_c;
    logic [31:0] held_f;

    rst = 1'b1; in_valid = 1'b0; mode = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    step();
    step();
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_c", c, 0);
    chk("rst_flags", flags(), 0);
    rst = 1'b0;
    step();
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);

    // single transfer: result visible two edges later
    step();
    drive(0);
    @(negedge clk);
    chk("lat_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_ov_cyc1", out_valid, 0);
    step();
    @(negedge clk);
    chk("lat_ov_cyc2", out_valid, 1);
    chk("lat_c", c, 18);
    chk("lat_flags", flags(), 0);
    step();
    @(negedge clk);
    chk("lat_drain", out_valid, 0);

    // back-to-back stream with a 3-cycle downstream stall
    wr = 0; rd = 0; acc = 0; prev_stall = 0; held_c = '0; held_f = '0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      step();
      if (acc) wr++;
      if (wr < N) drive(wr);
      else in_valid = 1'b0;
      out_ready = !(cyc >= 5 && cyc <= 7);
      @(negedge clk);
      if (out_valid && !out_ready) begin
        chk("stall_in_ready", in_ready, 0);
        if (prev_stall) begin
          chk("stall_c_hold", c, held_c);
          chk("stall_f_hold", flags(), held_f);
        end
        held_c = c;
        held_f = flags();
        prev_stall = 1;
      end else begin
        prev_stall = 0;
      end
      acc = in_valid && in_ready;
      if (out_valid && out_ready && rd < N) begin
        chk($sformatf("stream_c[%0d]", rd), c, ec[rd]);
        chk($sformatf("stream_f[%0d]", rd), flags(), ef[rd]);
        rd++;
      end
      if (rd == N && wr >= N) break;
    end
    chk("stream_count", rd, N);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    @(negedge clk);
    chk("stream_no_extra", out_valid, 0);

    // reset with both stages full
    drive(1);
    step();
    drive(2);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_full", out_valid, 1);
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("mid_rst_ov", out_valid, 0);
    chk("mid_rst_c", c, 0);
    chk("mid_rst_flags", flags(), 0);
    rst = 1'b0;
    step();
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_s1_flushed", out_valid, 0);
    drive(3);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_lat1", out_valid, 0);
    step();
    @(negedge clk);
    chk("post_rst_lat2", out_valid, 1);
    chk("post_rst_c", c, 25);
    chk("post_rst_flags", flags(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/exp_add_pipe.md
EXP_ADD_PIPE -- requirements
Module: exp_add_pipe

Interface
Parameters:
REQ-001 The block SHALL have parameter EXP_W, default 5, meaning the exponent field width in bits; legal range 3..11.
REQ-002 The block SHALL have parameter BIAS, default 15, meaning the exponent bias; it SHALL equal 2^(EXP_W-1)-1 for IEEE formats.

Ports (one clock; reset is synchronous and active-high):
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand pair valid.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 mode  input  1  0 = multiply (a+b-BIAS); 1 = divide (a-b+BIAS).
REQ-008 a  input  EXP_W  biased exponent of operand A.
REQ-009 b  input  EXP_W  biased exponent of operand B.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 c  output  EXP_W  biased result exponent, saturated.
REQ-013 ovf, unf, zero, special  output  1 each  overflow, underflow, zero-operand and inf/NaN-operand flags, qualified by out_valid.

Function
REQ-014 The block SHALL be a 2-stage pipeline (S1, S2); S2 registers drive the outputs directly.
REQ-015 Global enable en = out_ready | ~out_valid; in_ready SHALL equal en combinationally, and both stages SHALL advance only when en=1.
REQ-016 Input transfer SHALL occur on a cycle with in_valid & in_ready; S1 valid SHALL load in_valid when en=1; out_valid SHALL load S1 valid when en=1.
REQ-017 Latency SHALL be 2 cycles from input transfer to out_valid with no stall; throughput one result per cycle while out_ready=1.
REQ-018 S1 SHALL compute signed sum s, width EXP_W+2: mode 0 s = a+b; mode 1 s = a-b; and SHALL register the operand class (a==0, b==0, a==all-ones, b==all-ones) and mode.
REQ-019 S2 SHALL compute r = s-BIAS (mode 0) or r = s+BIAS (mode 1) in EXP_W+2 signed bits; no intermediate truncation.
REQ-020 Normal case: if 1 <= r <= 2^EXP_W-2, c SHALL equal r[EXP_W-1:0] and all flags SHALL be 0.
REQ-021 If r >= 2^EXP_W-1, c SHALL be all ones and ovf=1.
REQ-022 If r <= 0, c SHALL be 0 and unf=1.
REQ-023 Special (priority 1): mode 0 with a or b all-ones, or mode 1 with a all-ones or b==0, SHALL give special=1, c=all ones, ovf=unf=zero=0.
REQ-024 Zero (priority 2): mode 0 with a==0 or b==0, or mode 1 with a==0 (and not special), SHALL give zero=1, c=0, ovf=unf=0.
REQ-025 At most one of ovf, unf, zero, special SHALL be 1 per result.
REQ-026 While stalled (out_valid=1, out_ready=0), c, the flags and S1 contents SHALL hold unchanged, and in_ready SHALL be 0.
REQ-027 Inputs presented while in_ready=0 SHALL be ignored; no result SHALL be dropped or duplicated.

Reset
REQ-028 With rst=1 at a rising edge: S1 valid, out_valid, c, ovf, unf, zero and special SHALL all be 0; in-flight results SHALL be discarded.
REQ-029 rst SHALL override en; in_ready SHALL be 1 in the cycle after reset deasserts.

Verification (EXP_W=5, BIAS=15)
REQ-030 mode 0, a=16, b=17, out_ready=1 -> two cycles later out_valid=1, c=18, flags 0.
REQ-031 mode 0, a=30, b=30 -> c=31, ovf=1; mode 0, a=1, b=1 -> c=0, unf=1.
REQ-032 mode 1, a=20, b=10 -> c=25; mode 1, a=5, b=0 -> special=1, c=31; mode 0, a=0, b=31 -> special=1.
REQ-033 Back-to-back stream of 8 pairs with out_ready low for 3 cycles mid-stream -> all 8 results in order, c held during the stall, in_ready=0 during the stall.
REQ-034 Assert rst with both stages valid -> next cycle out_valid=0, c=0, all flags 0; first post-reset input returns its result with 2-cycle latency.
